ks60_seq: RTL and testbench

- Sequential 60x60 carry-less (GF(2)[x]) polynomial multiplier built around one shared combinational `ks30` core.
- Runs a 3-step Karatsuba schedule on that core: low half, high half, then the XOR of the halves.
- Combines the three partial products into a 119-bit product.
- Sits between the field-arithmetic controller and the reduction stage, with valid/ready handshakes on both sides.

---
 rtl/ks60_seq.sv | 185 ++++++++++++++++++
 tb/tb_ks60_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks60_seq.sv
// ks60_seq: sequential 60x60 carry-less (GF(2)[x]) polynomial multiplier.
//
// One shared combinational 30x30 Karatsuba core (ks30) is time-multiplexed over a
// three-step schedule: low halves (LO), high halves (HI), XOR of halves (MID).
// The three partial products are folded into the exact 119-bit product in MID,
// which is presented in DONE until the downstream handshake completes.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand pair valid
//   in_ready  out  block can accept operands
//   a, b      in   60-bit operand polynomials, bit i = coefficient of x^i
//   out_valid out  product valid
//   out_ready in   downstream accepts product
//   d         out  119-bit carry-less product a*b
//   busy      out  high in any state other than IDLE
//   op_count  out  products handed off, wraps modulo 2^CNT_W
module ks60_seq #(
  parameter int unsigned BACK2BACK = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [59:0]      a,
  input  logic [59:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [118:0]     d,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StMid, StDone} state_e;

  state_e             state_q, state_d;
  logic [59:0]        a_q, a_d, b_q, b_d;
  logic [58:0]        m_lo_q, m_lo_d, m_hi_q, m_hi_d;
  logic [118:0]       d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Holds in_ready low for the first cycle after reset release.
  logic               rdy_q;

  logic               accept, handoff;
  logic [29:0]        core_a, core_b;
  logic [58:0]        core_p;
  logic [58:0]        mid;
  logic [118:0]       prod;

  // 15x15 schoolbook carry-less multiply, the leaf of the Karatsuba core.
  function automatic logic [28:0] clmul15(input logic [14:0] x, input logic [14:0] y);
    logic [28:0] r;
    r = '0;
    for (int i = 0; i < 15; i++) begin
      if (y[i]) r = r ^ ({14'b0, x} << i);
    end
    return r;
  endfunction

  // ks30: one-level Karatsuba over 15-bit halves.
  always_comb begin : ks30
    logic [28:0] p_lo, p_hi, p_md;
    p_lo   = clmul15(core_a[14:0], core_b[14:0]);
    p_hi   = clmul15(core_a[29:15], core_b[29:15]);
    p_md   = clmul15(core_a[29:15] ^ core_a[14:0], core_b[29:15] ^ core_b[14:0]) ^ p_lo ^ p_hi;
    core_p = {30'b0, p_lo} ^ ({30'b0, p_md} << 15) ^ ({30'b0, p_hi} << 30);
  end

  // Core input mux; idle states drive zeros so the core does not toggle.
  always_comb begin
    core_a = '0;
    core_b = '0;
    unique case (state_q)
      StLo: begin
        core_a = a_q[29:0];
        core_b = b_q[29:0];
      end
      StHi: begin
        core_a = a_q[59:30];
        core_b = b_q[59:30];
      end
      StMid: begin
        core_a = a_q[59:30] ^ a_q[29:0];
        core_b = b_q[59:30] ^ b_q[29:0];
      end
      default: ;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign handoff = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StLo;
      StLo:   state_d = StHi;
      StHi:   state_d = StMid;
      StMid:  state_d = StDone;
      StDone: begin
        // accept is only possible here when back-to-back operation is enabled.
        if (handoff) state_d = accept ? StLo : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: in_ready = rdy_q;
      StDone: begin
        out_valid = 1'b1;
        in_ready  = (BACK2BACK != 32'd0) && out_ready;
      end
      default: ;
    endcase
  end

  // Karatsuba recombination: mid = (aL^aH)(bL^bH) ^ lo ^ hi.
  assign mid  = core_p ^ m_lo_q ^ m_hi_q;
  assign prod = {60'b0, m_lo_q} ^ ({60'b0, mid} << 30) ^ ({60'b0, m_hi_q} << 60);

  // Datapath next-state.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    m_lo_d = m_lo_q;
    m_hi_d = m_hi_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    if (accept) begin
      a_d = a;
      b_d = b;
    end
    if (state_q == StLo) m_lo_d = core_p;
    if (state_q == StHi) m_hi_d = core_p;
    if (state_q == StMid) begin
      d_d = prod;
    end else if (handoff) begin
      // Product is cleared as out_valid falls.
      d_d   = '0;
    end
    if (handoff) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      m_lo_q <= '0;
      m_hi_q <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      m_lo_q <= m_lo_d;
      m_hi_q <= m_hi_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      rdy_q  <= 1'b1;
    end
  end

  assign d        = d_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_ks60_seq.sv
module tb_ks60_seq;

  logic         clk;
  logic         rst_n;
  // Main DUT: BACK2BACK = 1, CNT_W = 16.
  logic         iv, ir, ov, ordy, bsy;
  logic [59:0]  a, b;
  logic [118:0] d;
  logic [15:0]  cnt;
  // Second DUT: BACK2BACK = 0, CNT_W = 2 (exercises the idle gap and counter wrap).
  logic         iv0, ir0, ov0, or0, bsy0;
  logic [59:0]  a0, b0;
  logic [118:0] d0;
  logic [1:0]   cnt0;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  ks60_seq #(.BACK2BACK(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .out_valid(ov), .out_ready(ordy), .d(d), .busy(bsy), .op_count(cnt)
  );

  ks60_seq #(.BACK2BACK(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0), .d(d0), .busy(bsy0), .op_count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial carry-less reference.
  function automatic logic [118:0] ref_mul(input logic [59:0] x, input logic [59:0] y);
    logic [118:0] r;
    r = '0;
    for (int i = 0; i < 60; i++) begin
      if (y[i]) r = r ^ ({59'b0, x} << i);
    end
    return r;
  endfunction

  function automatic logic [59:0] rnd60();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[59:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair into the main DUT (out_ready low) and wait for out_valid.
  task automatic do_op(input logic [59:0] xa, input logic [59:0] xb,
                       output logic [118:0] dq, output int lat, output logic irb);
    int w;
    iv = 1'b1; a = xa; b = xb; w = 0;
    #1;
    while (!ir && w < 20) begin tick(); w++; end
    tick();
    iv = 1'b0;
    irb = 1'b0; lat = 0;
    while (!ov && lat < 20) begin irb = irb | ir; tick(); lat++; end
    dq = d;
  endtask

  task automatic consume();
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({ov, bsy, ir, ov0, bsy0, ir0} !== 6'b0) begin
        bad++; $display("FAIL reset_flags: got %b want 000000", {ov, bsy, ir, ov0, bsy0, ir0});
      end
      total++;
      if (d !== 119'b0 || cnt !== 16'd0) begin
        bad++; $display("FAIL reset_data: d=%h cnt=%0d want 0/0", d, cnt);
      end
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (ir !== 1'b0) begin bad++; $display("FAIL ready_at_release: got %b want 0", ir); end
    tick();
    total++;
    if (ir !== 1'b1 || ir0 !== 1'b1) begin
      bad++; $display("FAIL ready_after_release: got %b%b want 11", ir, ir0);
    end
  endtask

  task automatic test_basic();
    logic [118:0] dq; int lat; logic irb;
    do_op(60'd1, 60'd1, dq, lat, irb);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", lat); end
    total++;
    if (dq !== 119'd1) begin bad++; $display("FAIL basic_d: got %h want 1", dq); end
    total++;
    if (irb !== 1'b0) begin bad++; $display("FAIL basic_ready_busy: got %b want 0", irb); end
    consume(); exp_cnt++;
    total++;
    if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL basic_count: got %0d want %0d", cnt, exp_cnt); end
    total++;
    if (ov !== 1'b0 || d !== 119'b0 || ir !== 1'b1) begin
      bad++; $display("FAIL basic_after: ov=%b d=%h ir=%b want 0/0/1", ov, d, ir);
    end
  endtask

  task automatic test_corners();
    logic [118:0] dq; int lat; logic irb;
    logic [59:0]  x;
    x = 60'h1 << 59;
    do_op(x, x, dq, lat, irb);
    total++;
    if (dq !== (119'h1 << 118)) begin bad++; $display("FAIL top_bit: got %h want bit118", dq); end
    consume(); exp_cnt++;
    x = (60'h1 << 30) | 60'h1;
    do_op(x, x, dq, lat, irb);
    total++;
    if (dq !== ((119'h1 << 60) | 119'h1)) begin
      bad++; $display("FAIL cross_cancel: got %h want 2^60+1", dq);
    end
    consume(); exp_cnt++;
    do_op(60'hFFF_FFFF_FFFF_FFFF, 60'hFFF_FFFF_FFFF_FFFF, dq, lat, irb);
    total++;
    if (dq !== 119'h555555555555555555555555555555) begin
      bad++; $display("FAIL all_ones: got %h want 555..5", dq);
    end
    consume(); exp_cnt++;
    total++;
    if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL corner_count: got %0d want %0d", cnt, exp_cnt); end
  endtask

  task automatic test_hold_b2b();
    logic [118:0] dq, e1, e2; int lat; logic irb;
    logic [59:0]  x1, y1, x2, y2;
    x1 = 60'h0AB_CDEF_0123_4567; y1 = 60'h987_6543_210F_EDCB;
    x2 = 60'h800_0000_0000_0001; y2 = 60'h3FF_F000_0000_FFFF;
    e1 = ref_mul(x1, y1); e2 = ref_mul(x2, y2);
    do_op(x1, y1, dq, lat, irb);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (ov !== 1'b1 || d !== e1 || ir !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d: ov=%b ir=%b d=%h want 1/0/%h", i, ov, ir, d, e1);
      end
    end
    ordy = 1'b1; iv = 1'b1; a = x2; b = y2;
    #1;
    total++;
    if (ir !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", ir); end
    tick();
    iv = 1'b0; ordy = 1'b0; exp_cnt++;
    total++;
    if (ov !== 1'b0 || bsy !== 1'b1 || cnt !== 16'(exp_cnt)) begin
      bad++; $display("FAIL b2b_accept: ov=%b busy=%b cnt=%0d want 0/1/%0d", ov, bsy, cnt, exp_cnt);
    end
    lat = 0;
    while (!ov && lat < 20) begin tick(); lat++; end
    total++;
    if (lat !== 3) begin bad++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    total++;
    if (d !== e2) begin bad++; $display("FAIL b2b_d: got %h want %h", d, e2); end
    consume(); exp_cnt++;
  endtask

  task automatic test_no_b2b();
    logic [59:0] x, y;
    int lat, w;
    x = 60'h123_4567_89AB_CDEF; y = 60'hFED_CBA9_8765_4321;
    iv0 = 1'b1; a0 = x; b0 = y;
    #1;
    total++;
    if (ir0 !== 1'b1) begin bad++; $display("FAIL nb_idle_ready: got %b want 1", ir0); end
    tick();
    iv0 = 1'b0;
    tick(); tick(); tick();
    total++;
    if (ov0 !== 1'b1 || d0 !== ref_mul(x, y)) begin
      bad++; $display("FAIL nb_first: ov=%b d=%h want 1/%h", ov0, d0, ref_mul(x, y));
    end
    x = 60'h00F_0F0F_0F0F_0F0F; y = 60'h0C3_C3C3_C3C3_C3C3;
    or0 = 1'b1; iv0 = 1'b1; a0 = x; b0 = y;
    #1;
    total++;
    if (ir0 !== 1'b0) begin bad++; $display("FAIL nb_done_ready: got %b want 0", ir0); end
    tick();
    total++;
    if (ov0 !== 1'b0 || ir0 !== 1'b1 || bsy0 !== 1'b0 || cnt0 !== 2'd1) begin
      bad++; $display("FAIL nb_idle_gap: ov=%b ir=%b busy=%b cnt=%0d want 0/1/0/1", ov0, ir0, bsy0, cnt0);
    end
    tick();
    iv0 = 1'b0; or0 = 1'b0;
    lat = 0;
    while (!ov0 && lat < 20) begin tick(); lat++; end
    total++;
    if (lat !== 3) begin bad++; $display("FAIL nb_latency: got %0d want 3", lat); end
    total++;
    if (d0 !== ref_mul(x, y)) begin bad++; $display("FAIL nb_d: got %h want %h", d0, ref_mul(x, y)); end
    or0 = 1'b1; tick(); or0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x = rnd60(); y = rnd60();
      iv0 = 1'b1; a0 = x; b0 = y; w = 0;
      #1;
      while (!ir0 && w < 20) begin tick(); w++; end
      tick();
      iv0 = 1'b0; w = 0;
      while (!ov0 && w < 20) begin tick(); w++; end
      total++;
      if (d0 !== ref_mul(x, y)) begin bad++; $display("FAIL nb_op%0d_d: got %h want %h", k, d0, ref_mul(x, y)); end
      or0 = 1'b1; tick(); or0 = 1'b0;
      total++;
      if (cnt0 !== 2'((3 + k) % 4)) begin
        bad++; $display("FAIL nb_wrap%0d: got %0d want %0d", k, cnt0, (3 + k) % 4);
      end
    end
  endtask

  task automatic test_abort();
    iv = 1'b1; a = 60'h555_5555_5555_5555; b = 60'hAAA_AAAA_AAAA_AAAA;
    #1;
    total++;
    if (ir !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", ir); end
    tick();
    iv = 1'b0;
    tick();
    total++;
    if (bsy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", bsy); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({ov, bsy, ir} !== 3'b0 || d !== 119'b0 || cnt !== 16'd0) begin
      bad++; $display("FAIL abort_clear: ov=%b busy=%b ir=%b d=%h cnt=%0d want all 0", ov, bsy, ir, d, cnt);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (ov !== 1'b0 || d !== 119'b0) begin
        bad++; $display("FAIL abort_stale%0d: ov=%b d=%h want 0/0", i, ov, d);
      end
    end
    total++;
    if (cnt !== 16'd0 || ir !== 1'b1 || bsy !== 1'b0) begin
      bad++; $display("FAIL abort_after: cnt=%0d ir=%b busy=%b want 0/1/0", cnt, ir, bsy);
    end
  endtask

  task automatic test_random();
    logic [118:0] q[$];
    logic [118:0] e;
    logic [59:0]  na, nb;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    na = rnd60(); nb = rnd60();
    while (recv < 1000 && cyc < 20000) begin
      ordy = 1'($urandom_range(0, 1));
      iv = (sent < 1000);
      a = na; b = nb;
      #1;
      if (ov && ordy) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_extra: unexpected product %h", d);
        end else begin
          e = q.pop_front();
          if (d !== e) begin bad++; $display("FAIL rand_d%0d: got %h want %h", recv, d, e); end
        end
        recv++;
      end
      if (iv && ir) begin
        q.push_back(ref_mul(na, nb));
        sent++;
        na = rnd60(); nb = rnd60();
      end
      tick();
      cyc++;
    end
    iv = 1'b0; ordy = 1'b0;
    total++;
    if (recv !== 1000) begin bad++; $display("FAIL rand_timeout: got %0d products want 1000", recv); end
    total++;
    if (cnt !== 16'd1000) begin bad++; $display("FAIL rand_count: got %0d want 1000", cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    iv = 1'b0; a = '0; b = '0; ordy = 1'b0;
    iv0 = 1'b0; a0 = '0; b0 = '0; or0 = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_hold_b2b();
    test_no_b2b();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
